fifo_read_scheduler: RTL
========================

# fifo_read_scheduler

Read-side scheduler for the receive FIFO. It shares the FIFO read port between N_REQ consumers, for example a host/register reader and a UART-TX loopback engine. It grants the port round-robin, issues exactly one `fifo_rdreq` pulse per grant, and returns the popped word to the granted consumer with a one-hot valid strobe. It sits between the FIFO (non-showahead, 1-cycle read latency) and its consumers, replacing per-consumer read edge-detect logic.

## Interface
- `DATA_W`, default 8, FIFO word width.
- `N_REQ`, default 2, number of requesters (≥2).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  N_REQ  level request per consumer; one word per high phase.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_q`  in  DATA_W  FIFO read data; valid the cycle after `fifo_rdreq`.
- `fifo_rdreq`  out  1  FIFO read strobe, registered, 1-cycle pulse.
- `gnt`  out  N_REQ  one-hot grant, high during the `fifo_rdreq` cycle.
- `data_out`  out  DATA_W  captured word; holds until the next capture.
- `data_valid`  out  N_REQ  one-hot, 1-cycle strobe to the owning consumer.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE → READ when any eligible requester exists and `!fifo_empty`.
  - READ → CAPTURE unconditionally.
  - CAPTURE → IDLE unconditionally.
- Eligibility: `req[i] & armed[i]`.
  - `armed[i]` clears when `i` is granted.
  - `armed[i]` sets on any cycle where `req[i]==0`.
  - A held-high `req` therefore yields exactly one word. The consumer must drop `req` for ≥1 cycle to re-arm.
- Round-robin arbitration:
  - Pointer `last` holds the index of the most recent grant.
  - Search starts at `last+1`, modulo N_REQ. The first eligible index wins.
  - `last` updates on the IDLE→READ transition only.
- In READ: `fifo_rdreq=1`, `gnt[idx]=1`.
- In CAPTURE: sample `fifo_q` into `data_out` at the end of the cycle. `data_valid[idx]` is registered high for the following cycle only.
- `fifo_empty` is sampled only in IDLE. This block is the sole reader, so the FIFO cannot empty between grant and pop. Concurrent writes are irrelevant.
- Empty with eligible requesters: stay in IDLE. Requests stay armed and pending with no timeout.
- A requester dropping `req` after grant still receives its `data_valid`; the word is not discarded.
- Reset values:
  - state=IDLE, `last=N_REQ-1` (so index 0 has first priority).
  - `armed` all 1.
  - `fifo_rdreq`, `gnt`, `data_valid`, `busy` all 0.
  - `data_out` = 0.
- Reset mid-operation: all outputs return to reset values the next cycle. A word already popped in READ is lost; this is acceptable.

## Timing
- Eligible req and `!fifo_empty` seen in cycle t → `gnt`/`fifo_rdreq` in t+1 → `fifo_q` valid in t+2 → `data_out`/`data_valid` in t+3.
- IDLE is re-entered in t+3. A new grant can issue `fifo_rdreq` in t+4, giving a peak throughput of 1 word per 3 cycles.
- `data_valid` for grant k and `gnt` for grant k+1 never coincide.
- `busy` is high in t+1 and t+2.

## Structure
- Shared package `fifo_ctrl_pkg`:
  - state encoding constants IDLE/READ/CAPTURE, 2 bits.
  - default DATA_W.
- Sub-module `rr_arbiter`: combinational; inputs eligible vector and `last`; outputs one-hot grant and encoded index. The top holds the FSM, `armed`, `last` and the data register.

## Test plan
- Single word: FIFO holds 0xA5, `req=01` held high.
  - `fifo_rdreq` pulses once, 1 cycle after req is seen.
  - `data_out=0xA5` with `data_valid=01` 3 cycles after req.
  - No second pop while `req` is held.
- Round-robin: FIFO holds 0x11, 0x22, 0x33, 0x44; both reqs toggle high/low continuously.
  - Grants alternate 0,1,0,1.
  - `data_valid` order is 01(0x11), 10(0x22), 01(0x33), 10(0x44).
- Empty stall: `req=11`, FIFO empty for 10 cycles, then 0x5A written.
  - No `fifo_rdreq` while empty.
  - Index 0 receives 0x5A, with `fifo_rdreq` issued 1 cycle after `fifo_empty` is seen low.
- Re-arm: `req[1]` held high across 3 FIFO words. Expect 1 delivery only; after `req[1]` drops for 1 cycle and rises again, expect the next word.
- Reset in READ: assert `rst` in the `fifo_rdreq` cycle.
  - No `data_valid` is produced; outputs are 0 the next cycle.
  - After release, index 0 has priority.
- Late drop: `req[0]` falls in the READ cycle. `data_valid=01` is still asserted with the popped word.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the receive-FIFO control blocks.
package fifo_ctrl_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_read_scheduler_if.sv
// Consumer/FIFO-side signal bundle of the FIFO read scheduler.
interface fifo_read_scheduler_if
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned N_REQ  = 2
);

    logic [N_REQ-1:0]  req;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_q;
    logic              fifo_rdreq;
    logic [N_REQ-1:0]  gnt;
    logic [DATA_W-1:0] data_out;
    logic [N_REQ-1:0]  data_valid;
    logic              busy;

    modport master (
        input  req, fifo_empty, fifo_q,
        output fifo_rdreq, gnt, data_out, data_valid, busy
    );

    modport slave (
        output req, fifo_empty, fifo_q,
        input  fifo_rdreq, gnt, data_out, data_valid, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible index after `last` wins.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((32'(last) + k) % N_REQ);
            if (!found && eligible[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_read_scheduler.sv
// Round-robin scheduler sharing one non-showahead FIFO read port between N_REQ consumers;
// one pop per request high phase, word returned with a one-hot valid strobe.
module fifo_read_scheduler
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned N_REQ  = 2
) (
    input logic                   clk,
    input logic                   rst,
    fifo_read_scheduler_if.master bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  armed_q, armed_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  valid_q, valid_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic              rdreq_q, rdreq_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_found;

    assign eligible = bus.req & armed_q;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .eligible (eligible),
        .last     (last_q),
        .grant    (arb_grant),
        .idx      (arb_idx),
        .found    (arb_found)
    );

    always_comb begin
        state_d = state_q;
        armed_d = armed_q | ~bus.req;
        last_d  = last_q;
        rdreq_d = 1'b0;
        gnt_d   = '0;
        valid_d = '0;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (arb_found && !bus.fifo_empty) begin
                    state_d = READ;
                    rdreq_d = 1'b1;
                    gnt_d   = arb_grant;
                    last_d  = arb_idx;
                    armed_d = (armed_q & ~arb_grant) | ~bus.req;
                end
            end
            READ: state_d = CAPTURE;
            CAPTURE: begin
                // last_q still names the owner of the in-flight word.
                state_d         = IDLE;
                data_d          = bus.fifo_q;
                valid_d[last_q] = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            armed_q <= '1;
            last_q  <= IDX_W'(N_REQ - 1);
            rdreq_q <= 1'b0;
            gnt_q   <= '0;
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            last_q  <= last_d;
            rdreq_q <= rdreq_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.fifo_rdreq = rdreq_q;
    assign bus.gnt        = gnt_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = (state_q != IDLE);

endmodule
